cond_branch_unit: RTL and testbench

Conditional-branch resolver for the pipelined 64-bit CPU. It is the consumer end of the ALU flag interface.
- Holds the architectural NZCV flag register, written by flag-setting instructions (ADDS/SUBS/ANDS).
- Evaluates B.cond, CBZ, CBNZ and B against those flags or against the ALU zero output.
- Issues a registered fetch redirect.
- Stalls the front end while a needed flag result is still in flight.

---
 rtl/cond_branch_unit_if.sv | 30 +++
 rtl/cond_branch_unit.sv | 157 +++++++++++++++
 tb/tb_cond_branch_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cond_branch_unit_if.sv
// Signal bundle between the front end / ALU and the conditional-branch resolver.
interface cond_branch_unit_if #(parameter int ADDR_W = 64);
  logic              flag_we;
  logic              alu_negative;
  logic              alu_zero;
  logic              alu_overflow;
  logic              alu_carry_out;
  logic              flags_inflight;
  logic              br_valid;
  logic [1:0]        br_type;
  logic [3:0]        br_cond;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] br_offset;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [3:0]        flags_q;

  modport master (
    output flag_we, alu_negative, alu_zero, alu_overflow, alu_carry_out,
           flags_inflight, br_valid, br_type, br_cond, br_pc, br_offset,
    input  stall, redirect_valid, redirect_pc, flags_q
  );

  modport slave (
    input  flag_we, alu_negative, alu_zero, alu_overflow, alu_carry_out,
           flags_inflight, br_valid, br_type, br_cond, br_pc, br_offset,
    output stall, redirect_valid, redirect_pc, flags_q
  );
endinterface

// File: rtl/cond_branch_unit.sv
// Conditional-branch resolver: NZCV flag register, B/B.cond/CBZ/CBNZ evaluation, registered redirect.
// Optional macro COND_BYPASS_EN forwards live ALU flags to branches on flag_we.
module cond_branch_unit #(
  parameter int ADDR_W = 64
) (
  input logic               clk,
  input logic               reset,
  cond_branch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_flags;
  logic [3:0]        r_cond;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_off;
  logic              r_redirValid;
  logic [ADDR_W-1:0] r_redirPc;

  logic [3:0]        w_liveFlags;
  logic [3:0]        w_effFlags;
  logic              w_flagsReady;
  logic              w_stall;
  logic              w_capture;
  logic              w_resolve;
  logic              w_taken;
  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_off;

  // Flags are packed {N,Z,C,V}.
  function automatic logic condTrue(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'h0:    condTrue = z;
      4'h1:    condTrue = !z;
      4'h2:    condTrue = cy;
      4'h3:    condTrue = !cy;
      4'h4:    condTrue = n;
      4'h5:    condTrue = !n;
      4'h6:    condTrue = v;
      4'h7:    condTrue = !v;
      4'h8:    condTrue = cy & !z;
      4'h9:    condTrue = !(cy & !z);
      4'hA:    condTrue = (n == v);
      4'hB:    condTrue = (n != v);
      4'hC:    condTrue = !z & (n == v);
      4'hD:    condTrue = !(!z & (n == v));
      default: condTrue = 1'b1;
    endcase
  endfunction

  assign w_liveFlags = {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};

`ifdef COND_BYPASS_EN
  assign w_effFlags   = bus.flag_we ? w_liveFlags : r_flags;
  assign w_flagsReady = !bus.flags_inflight || bus.flag_we;
`else
  assign w_effFlags   = r_flags;
  assign w_flagsReady = !bus.flags_inflight;
`endif

  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_capture = 1'b0;
    w_resolve = 1'b0;
    w_taken   = 1'b0;
    w_pc      = r_pc;
    w_off     = r_off;
    case (r_state)
      IDLE: begin
        if (bus.br_valid) begin
          if (bus.br_type == 2'b01 && !w_flagsReady) begin
            w_capture = 1'b1;
            w_stall   = 1'b1;
            w_next    = WAIT;
          end else begin
            w_resolve = 1'b1;
            w_pc      = bus.br_pc;
            w_off     = bus.br_offset;
            case (bus.br_type)
              2'b00:   w_taken = 1'b1;
              2'b01:   w_taken = condTrue(bus.br_cond, w_effFlags);
              2'b10:   w_taken = bus.alu_zero;
              default: w_taken = !bus.alu_zero;
            endcase
          end
        end
      end
      WAIT: begin
        w_stall = 1'b1;
        if (bus.flag_we) begin
`ifdef COND_BYPASS_EN
          w_resolve = 1'b1;
          w_taken   = condTrue(r_cond, w_liveFlags);
          w_stall   = 1'b0;
          w_next    = IDLE;
`else
          w_next    = RESOLVE;
`endif
        end
      end
      RESOLVE: begin
        w_stall   = 1'b1;
        w_resolve = 1'b1;
        w_taken   = condTrue(r_cond, r_flags);
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_flags <= 4'b0000;
      r_cond  <= 4'h0;
      r_pc    <= '0;
      r_off   <= '0;
    end else begin
      r_state <= w_next;
      if (bus.flag_we) r_flags <= w_liveFlags;
      if (w_capture) begin
        r_cond <= bus.br_cond;
        r_pc   <= bus.br_pc;
        r_off  <= bus.br_offset;
      end
    end
  end

  // Redirect is a one-cycle pulse; the target only moves on a taken branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_redirValid <= 1'b0;
      r_redirPc    <= '0;
    end else begin
      r_redirValid <= w_resolve & w_taken;
      if (w_resolve && w_taken) r_redirPc <= w_pc + w_off;
    end
  end

  assign bus.stall          = w_stall;
  assign bus.redirect_valid = r_redirValid;
  assign bus.redirect_pc    = r_redirPc;
  assign bus.flags_q        = r_flags;

endmodule

// File: tb/tb_cond_branch_unit.sv
// Directed self-checking bench for cond_branch_unit; expectations follow COND_BYPASS_EN.
module tb_cond_branch_unit;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  cond_branch_unit_if #(.ADDR_W(64)) bus ();

  cond_branch_unit #(.ADDR_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setFlags(input logic n, input logic z, input logic c, input logic v);
    bus.alu_negative  = n;
    bus.alu_zero      = z;
    bus.alu_carry_out = c;
    bus.alu_overflow  = v;
  endtask

  task automatic setBranch(input logic [1:0] t, input logic [3:0] c, input logic [63:0] pc, input logic [63:0] off);
    bus.br_valid  = 1'b1;
    bus.br_type   = t;
    bus.br_cond   = c;
    bus.br_pc     = pc;
    bus.br_offset = off;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.flag_we = 1'b0;
    setFlags(1'b0, 1'b0, 1'b0, 1'b0);
    bus.flags_inflight = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_type   = 2'b00;
    bus.br_cond   = 4'h0;
    bus.br_pc     = '0;
    bus.br_offset = '0;
    tick();
    tick();
    checks++; if (bus.flags_q !== 4'b0000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=0000", bus.flags_q); end
    checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rv got=%b exp=0", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 64'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=0", bus.redirect_pc); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b exp=0", bus.stall); end
    reset = 1'b0;
    tick();
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_stall got=%b exp=0", bus.stall); end
  endtask

  task automatic test_bcond_eq_ne();
    bus.flag_we = 1'b1;
    setFlags(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    bus.flag_we = 1'b0;
    checks++; if (bus.flags_q !== 4'b0110) begin failures++; $display("[TB] FAIL flags_latch got=%b exp=0110", bus.flags_q); end
    setFlags(1'b0, 1'b0, 1'b0, 1'b0);
    setBranch(2'b01, 4'h0, 64'h1000, 64'h40);
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL eq_stall got=%b exp=0", bus.stall); end
    tick();
    bus.br_valid = 1'b0;
    checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL eq_rv got=%b exp=1", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 64'h1040) begin failures++; $display("[TB] FAIL eq_pc got=%h exp=1040", bus.redirect_pc); end
    tick();
    checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL eq_pulse got=%b exp=0", bus.redirect_valid); end
    setBranch(2'b01, 4'h1, 64'h2000, 64'h40);
    tick();
    bus.br_valid = 1'b0;
    checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL ne_rv got=%b exp=0", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 64'h1040) begin failures++; $display("[TB] FAIL ne_pc_hold got=%h exp=1040", bus.redirect_pc); end
  endtask

  // Flags are N=0 Z=1 C=1 V=0 here; bit i of expTaken is the hand-evaluated result of condition i.
  task automatic test_back_to_back();
    logic [15:0] expTaken;
    expTaken = 16'hE6A5;
    for (int i = 0; i < 16; i++) begin
      setBranch(2'b01, 4'(i), 64'h5000 + 64'(i) * 64'h100, 64'h8);
      tick();
      checks++; if (bus.redirect_valid !== expTaken[i]) begin failures++; $display("[TB] FAIL cond_%0d_rv got=%b exp=%b", i, bus.redirect_valid, expTaken[i]); end
    end
    bus.br_valid = 1'b0;
    tick();
    checks++; if (bus.redirect_pc !== 64'h5F08) begin failures++; $display("[TB] FAIL b2b_last_pc got=%h exp=5f08", bus.redirect_pc); end
  endtask

  task automatic test_wait();
    bus.flags_inflight = 1'b1;
    setBranch(2'b01, 4'hA, 64'h3000, 64'h100);
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("[TB] FAIL wait_stall_rise got=%b exp=1", bus.stall); end
    tick();
    bus.br_valid = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("[TB] FAIL wait_stall_hold got=%b exp=1", bus.stall); end
    tick();
    checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL wait_no_rv got=%b exp=0", bus.redirect_valid); end
    bus.flag_we = 1'b1;
    bus.flags_inflight = 1'b0;
    setFlags(1'b1, 1'b0, 1'b0, 1'b1);
    #1;
`ifdef COND_BYPASS_EN
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL wait_fwe_stall got=%b exp=0", bus.stall); end
`else
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("[TB] FAIL wait_fwe_stall got=%b exp=1", bus.stall); end
`endif
    tick();
    bus.flag_we = 1'b0;
    setFlags(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.flags_q !== 4'b1001) begin failures++; $display("[TB] FAIL wait_flags got=%b exp=1001", bus.flags_q); end
`ifdef COND_BYPASS_EN
    checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL wait_rv got=%b exp=1", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 64'h3100) begin failures++; $display("[TB] FAIL wait_pc got=%h exp=3100", bus.redirect_pc); end
    tick();
    checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL wait_pulse got=%b exp=0", bus.redirect_valid); end
`else
    checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL resolve_early_rv got=%b exp=0", bus.redirect_valid); end
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("[TB] FAIL resolve_stall got=%b exp=1", bus.stall); end
    tick();
    checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL resolve_rv got=%b exp=1", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 64'h3100) begin failures++; $display("[TB] FAIL resolve_pc got=%h exp=3100", bus.redirect_pc); end
`endif
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL wait_done_stall got=%b exp=0", bus.stall); end
  endtask

  // flags_q is 1001 (Z=0); the coincident flag_we carries Z=1.
  task automatic test_coincident_flag_we();
    bus.flag_we = 1'b1;
    setFlags(1'b0, 1'b1, 1'b1, 1'b0);
    setBranch(2'b01, 4'h0, 64'h7000, 64'h20);
    tick();
    bus.flag_we  = 1'b0;
    bus.br_valid = 1'b0;
    setFlags(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.flags_q !== 4'b0110) begin failures++; $display("[TB] FAIL coinc_flags got=%b exp=0110", bus.flags_q); end
`ifdef COND_BYPASS_EN
    checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL coinc_rv got=%b exp=1", bus.redirect_valid); end
`else
    checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL coinc_rv got=%b exp=0", bus.redirect_valid); end
`endif
  endtask

  task automatic test_cbz_cbnz();
    bus.flags_inflight = 1'b1;
    setFlags(1'b0, 1'b1, 1'b0, 1'b0);
    setBranch(2'b10, 4'h0, 64'h8000, 64'h44);
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL cbz_stall got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL cbz_rv got=%b exp=1", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 64'h8044) begin failures++; $display("[TB] FAIL cbz_pc got=%h exp=8044", bus.redirect_pc); end
    setBranch(2'b11, 4'h0, 64'h9000, 64'h44);
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL cbnz_stall got=%b exp=0", bus.stall); end
    tick();
    bus.br_valid = 1'b0;
    bus.flags_inflight = 1'b0;
    setFlags(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL cbnz_rv got=%b exp=0", bus.redirect_valid); end
  endtask

  task automatic test_wrap();
    setBranch(2'b00, 4'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10);
    tick();
    bus.br_valid = 1'b0;
    checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL wrap_rv got=%b exp=1", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 64'h8) begin failures++; $display("[TB] FAIL wrap_pc got=%h exp=8", bus.redirect_pc); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    bus.flags_inflight = 1'b1;
    setBranch(2'b01, 4'hE, 64'hA000, 64'h4);
    tick();
    bus.br_valid = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("[TB] FAIL mid_wait_stall got=%b exp=1", bus.stall); end
    reset = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.redirect_pc !== 64'h0) begin failures++; $display("[TB] FAIL mid_reset_pc got=%h exp=0", bus.redirect_pc); end
    checks++; if (bus.flags_q !== 4'b0000) begin failures++; $display("[TB] FAIL mid_reset_flags got=%b exp=0000", bus.flags_q); end
    tick();
    reset = 1'b0;
    bus.flags_inflight = 1'b0;
    tick();
    bus.flag_we = 1'b1;
    setFlags(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    bus.flag_we = 1'b0;
    checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL dropped_rv1 got=%b exp=0", bus.redirect_valid); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL dropped_stall got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL dropped_rv2 got=%b exp=0", bus.redirect_valid); end
    setBranch(2'b00, 4'h0, 64'hB000, 64'h10);
    tick();
    bus.br_valid = 1'b0;
    checks++; if (bus.redirect_pc !== 64'hB010) begin failures++; $display("[TB] FAIL idle_after_reset_pc got=%h exp=b010", bus.redirect_pc); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_bcond_eq_ne();
    test_back_to_back();
    test_wait();
    test_coincident_flag_we();
    test_cbz_cbnz();
    test_wrap();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
